matrix_result_collector: RTL and testbench
==========================================

# matrix_result_collector

Result-side responder for `sequential_matrix_multiplier`. It answers the `z_stb`/`z_ack` handshake and stores every streamed value into an M×M result buffer at (`z_i`, `z_j`); a later value for the same cell overwrites the earlier partial sum. It also counts writes, checks completeness when the multiplier's `done` rises, and then drains the final matrix in row-major order over a second stb/ack handshake. It sits between the multiplier and the host/testbench sink, and also offers a random-access read port.

## Interface
- `M`, default 4: matrix dimension; legal range 2..16.
- `WIDTH`, default 32: data width (IEEE-754 single from the multiplier).
- `ACK_DELAY`, default 0: extra wait cycles before `z_ack` is asserted; legal range 0..15.

- `clk`, in, 1: clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `clear`, in, 1: synchronous clear of state, counters, valid bits and flags. Buffer data is not cleared.
- `z_out`, in, WIDTH: result value from the multiplier.
- `z_i`, `z_j`, in, 5 each: result row and column.
- `z_stb`, in, 1: result valid.
- `z_ack`, out, 1: one-cycle acknowledge.
- `mult_done`, in, 1: multiplier `done`, treated as a level; only its rising edge is used.
- `rd_i`, `rd_j`, in, 5 each: random-access read address.
- `rd_data`, out, WIDTH: registered read data, 1-cycle latency.
- `out_data`, out, WIDTH: drain data.
- `out_i`, `out_j`, out, 5 each: drain indices.
- `out_stb`, out, 1: drain data valid.
- `out_ack`, in, 1: drain acknowledge from the sink.
- `drain_done`, out, 1: one-cycle pulse after the last element is drained.
- `err`, out, 1: sticky error flag; cleared only by `rst` or `clear`.

## Operation
**State machine:** IDLE, DELAY, ACK, RELEASE, DRAIN.
- **IDLE**
  - `z_stb`=1 → DELAY if `ACK_DELAY`>0, else → ACK.
  - Else if `done_pend`=1 → DRAIN, with the drain index reset to (0,0).
- **DELAY:** counts `ACK_DELAY` cycles, then → ACK. `z_stb` is assumed held high; if it drops here, return to IDLE with no write.
- **ACK**
  - `z_ack`=1 for this cycle only.
  - At the closing edge, `z_out` is written to `buf[z_i][z_j]`, `valid[z_i][z_j]` is set, and `wr_cnt` increments (saturating).
  - → RELEASE.
- **RELEASE:** waits for `z_stb`=0, then → IDLE. This prevents a double-ack while the multiplier drops its strobe.
- **DRAIN**
  - Presents `buf` at (`out_i`, `out_j`) with `out_stb`=1.
  - On `out_ack`, advance `out_j`, wrapping at M−1 to 0 and incrementing `out_i`.
  - On the ack of element (M−1, M−1): `out_stb`→0, `drain_done` pulses, → IDLE, `done_pend` cleared.

**mult_done handling**
- A rising edge of `mult_done` sets `done_pend` in any state.
- At that edge, `err` is set if `wr_cnt` ≠ M³ or any `valid` bit is 0.
- Drain starts only from IDLE, so an in-flight handshake always completes first.

**Other rules**
- Out-of-range indices (`z_i`≥M or `z_j`≥M): the value is acknowledged normally, no write or count happens, and `err` is set.
- `wr_cnt` is clog2(M³+1) bits wide and saturates at its maximum value.
- Read port: `rd_data` <= `buf[rd_i][rd_j]` every cycle. An out-of-range address returns 0.
- Write and read of the same cell in one cycle: `rd_data` returns the old value.
- `clear` has priority over every state: → IDLE, `z_ack`/`out_stb`/`drain_done`=0, `wr_cnt`/`valid`/`done_pend`/`err`=0.

## Timing
- **Reset values:** all outputs 0 (`z_ack`, `rd_data`, `out_data`, `out_i`, `out_j`, `out_stb`, `drain_done`, `err`). State is IDLE, counters 0, `valid` all 0. Buffer contents are undefined.
- **Handshake latency:** `z_stb` sampled high at edge E0 → `z_ack` high from E0+`ACK_DELAY`+1 for exactly one cycle → buffer updated at the next edge.
  - Minimum spacing between acks is 3 cycles when `ACK_DELAY`=0.
- **Drain:** the first `out_stb` appears 1 cycle after IDLE is entered with `done_pend` set. `out_data`/`out_i`/`out_j` stay stable while `out_stb`=1 and `out_ack`=0.
- **Drain throughput:** with `out_ack` held high, one element per cycle; the whole matrix drains in M² cycles. `drain_done` is asserted in the cycle after the last ack.
- **Reset mid-operation:** `rst` or `clear` during DELAY/ACK/DRAIN aborts immediately. No partial write occurs if the abort lands before the ACK closing edge.

## Test plan
- **Single handshake:** `ACK_DELAY`=0, `z_stb`=1 with `z_out`=0x3F800000 at (1,2), held until ack → `z_ack` pulses 1 cycle after the `z_stb` edge; `rd_i`/`rd_j`=(1,2) returns 0x3F800000; `wr_cnt`=1.
- **Overwrite:** three values at (0,0): 0x3F800000, 0x40000000, 0x40400000 → three acks, final read 0x40400000, `wr_cnt`=3.
- **Full run:** M=4, 64 writes covering all 16 cells, `mult_done` rises, `out_ack` tied high → 16 row-major elements (0,0)…(3,3) on 16 consecutive cycles, `drain_done` pulse, `err`=0.
- **Backpressure:** `out_ack` toggling 0/1 → each element held stable until acked, none skipped or duplicated.
- **Errors:** `z_i`=5 with M=4 → acked, no write, `err`=1. Separately, `mult_done` after 63 writes → `err`=1 and the drain still occurs.
- **Abort and delay:** `clear` asserted during DRAIN at element 7 → `out_stb` 0 next cycle, state IDLE, `err`=0. With `ACK_DELAY`=3 → `z_ack` arrives 4 cycles after `z_stb` is sampled.

Source files
------------

// File: rtl/matrix_result_collector.sv
// Result-side responder for the sequential matrix multiplier: acknowledges streamed
// results into an MxM buffer, checks completeness on done, then drains row-major.
module matrix_result_collector #(
  parameter int M         = 4,
  parameter int WIDTH     = 32,
  parameter int ACK_DELAY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] z_out,
  input  logic [4:0]       z_i,
  input  logic [4:0]       z_j,
  input  logic             z_stb,
  output logic             z_ack,
  input  logic             mult_done,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rd_j,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_i,
  output logic [4:0]       out_j,
  output logic             out_stb,
  input  logic             out_ack,
  output logic             drain_done,
  output logic             err
);

  localparam int                CELLS    = M * M;
  localparam int                ADDR_W   = $clog2(CELLS);
  localparam int                CUBE     = M * M * M;
  localparam int                CNT_W    = $clog2(CUBE + 1);
  localparam logic [4:0]        M_IDX    = 5'(M);
  localparam logic [4:0]        M_LAST   = 5'(M - 1);
  localparam logic [ADDR_W-1:0] M_ADDR   = ADDR_W'(M);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CUBE);
  localparam logic [3:0]        DLY_LAST = (ACK_DELAY > 0) ? 4'(ACK_DELAY - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_ACK,
    S_RELEASE,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0]  r_buf [CELLS];
  logic [CELLS-1:0]  r_valid;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [3:0]        r_dly_cnt;
  logic              r_done_pend;
  logic              r_mult_done_d;
  logic              r_err;
  logic              r_drain_done;
  logic [4:0]        r_out_i;
  logic [4:0]        r_out_j;
  logic [ADDR_W-1:0] r_out_addr;
  logic [WIDTH-1:0]  r_out_data;
  logic [WIDTH-1:0]  r_rd_data;

  logic              w_z_in_range;
  logic              w_rd_in_range;
  logic [ADDR_W-1:0] w_z_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_out_addr_next;
  logic              w_out_last;
  logic              w_done_rise;
  logic              w_wr_en;
  logic              w_drain_start;
  logic              w_drain_step;
  logic              w_drain_last;

  // Indices are only meaningful when in range; truncation outside range is harmless
  // because every use is qualified by the range check.
  assign w_z_in_range    = (z_i < M_IDX) && (z_j < M_IDX);
  assign w_rd_in_range   = (rd_i < M_IDX) && (rd_j < M_IDX);
  assign w_z_addr        = ADDR_W'(z_i) * M_ADDR + ADDR_W'(z_j);
  assign w_rd_addr       = ADDR_W'(rd_i) * M_ADDR + ADDR_W'(rd_j);
  assign w_out_addr_next = r_out_addr + ADDR_W'(1);
  assign w_out_last      = (r_out_i == M_LAST) && (r_out_j == M_LAST);
  assign w_done_rise     = mult_done && !r_mult_done_d;
  assign w_wr_en         = (r_state == S_ACK) && w_z_in_range && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    z_ack         = 1'b0;
    out_stb       = 1'b0;
    w_drain_start = 1'b0;
    w_drain_step  = 1'b0;
    w_drain_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (z_stb) begin
          w_state_next = (ACK_DELAY > 0) ? S_DELAY : S_ACK;
        end else if (r_done_pend) begin
          w_state_next  = S_DRAIN;
          w_drain_start = 1'b1;
        end
      end
      S_DELAY: begin
        if (!z_stb) begin
          w_state_next = S_IDLE;
        end else if (r_dly_cnt == DLY_LAST) begin
          w_state_next = S_ACK;
        end
      end
      S_ACK: begin
        z_ack        = 1'b1;
        w_state_next = S_RELEASE;
      end
      S_RELEASE: begin
        // Hold off until the multiplier drops its strobe to avoid a second ack.
        if (!z_stb) begin
          w_state_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        out_stb = 1'b1;
        if (out_ack) begin
          if (w_out_last) begin
            w_state_next = S_IDLE;
            w_drain_last = 1'b1;
          end else begin
            w_drain_step = 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (clear) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dly_cnt <= 4'd0;
    end else if (r_state == S_DELAY) begin
      r_dly_cnt <= r_dly_cnt + 4'd1;
    end else begin
      r_dly_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid       <= '0;
      r_wr_cnt      <= '0;
      r_done_pend   <= 1'b0;
      r_mult_done_d <= 1'b0;
      r_err         <= 1'b0;
      r_drain_done  <= 1'b0;
      r_out_i       <= 5'd0;
      r_out_j       <= 5'd0;
      r_out_addr    <= '0;
    end else begin
      r_mult_done_d <= mult_done;
      if (clear) begin
        r_valid      <= '0;
        r_wr_cnt     <= '0;
        r_done_pend  <= 1'b0;
        r_err        <= 1'b0;
        r_drain_done <= 1'b0;
      end else begin
        r_drain_done <= w_drain_last;
        if (r_state == S_ACK) begin
          if (w_z_in_range) begin
            r_valid[w_z_addr] <= 1'b1;
            if (r_wr_cnt != '1) begin
              r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
          end else begin
            r_err <= 1'b1;
          end
        end
        if (w_drain_start) begin
          r_out_i    <= 5'd0;
          r_out_j    <= 5'd0;
          r_out_addr <= '0;
        end
        if (w_drain_step) begin
          r_out_addr <= w_out_addr_next;
          if (r_out_j == M_LAST) begin
            r_out_j <= 5'd0;
            r_out_i <= r_out_i + 5'd1;
          end else begin
            r_out_j <= r_out_j + 5'd1;
          end
        end
        if (w_drain_last) begin
          r_done_pend <= 1'b0;
        end
        // A new done edge wins over a drain finishing in the same cycle.
        if (w_done_rise) begin
          r_done_pend <= 1'b1;
          if ((r_wr_cnt != CNT_FULL) || !(&r_valid)) begin
            r_err <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_buf[w_z_addr] <= z_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_out_data <= '0;
    end else begin
      r_rd_data <= w_rd_in_range ? r_buf[w_rd_addr] : '0;
      if (w_drain_start) begin
        r_out_data <= r_buf[0];
      end else if (w_drain_step) begin
        r_out_data <= r_buf[w_out_addr_next];
      end
    end
  end

  assign rd_data    = r_rd_data;
  assign out_data   = r_out_data;
  assign out_i      = r_out_i;
  assign out_j      = r_out_j;
  assign drain_done = r_drain_done;
  assign err        = r_err;

endmodule

// File: tb/tb_matrix_result_collector.sv
// Directed bench for matrix_result_collector: handshake table, drain, backpressure,
// error, clear-abort and ACK_DELAY cases.
module tb_matrix_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [31:0] z_out;
  logic [4:0]  z_i, z_j;
  logic        z_stb, z_ack;
  logic        mult_done;
  logic [4:0]  rd_i, rd_j;
  logic [31:0] rd_data, out_data;
  logic [4:0]  out_i, out_j;
  logic        out_stb, out_ack, drain_done, err;

  logic [31:0] z_out_d;
  logic [4:0]  zi_d, zj_d, rdi_d, rdj_d;
  logic        zs_d, za_d;
  logic [31:0] rdd_d, od_d;
  logic [4:0]  oi_d, oj_d;
  logic        os_d, dd_d, err_d;
  logic        clear_d, mdone_d, oack_d;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_mem [16];

  always #5 clk = ~clk;

  matrix_result_collector #(.M(4), .WIDTH(32), .ACK_DELAY(0)) dut (
    .clk(clk), .rst(rst), .clear(clear), .z_out(z_out), .z_i(z_i), .z_j(z_j),
    .z_stb(z_stb), .z_ack(z_ack), .mult_done(mult_done), .rd_i(rd_i), .rd_j(rd_j),
    .rd_data(rd_data), .out_data(out_data), .out_i(out_i), .out_j(out_j),
    .out_stb(out_stb), .out_ack(out_ack), .drain_done(drain_done), .err(err)
  );

  matrix_result_collector #(.M(4), .WIDTH(32), .ACK_DELAY(3)) dut_d (
    .clk(clk), .rst(rst), .clear(clear_d), .z_out(z_out_d), .z_i(zi_d), .z_j(zj_d),
    .z_stb(zs_d), .z_ack(za_d), .mult_done(mdone_d), .rd_i(rdi_d), .rd_j(rdj_d),
    .rd_data(rdd_d), .out_data(od_d), .out_i(oi_d), .out_j(oj_d),
    .out_stb(os_d), .out_ack(oack_d), .drain_done(dd_d), .err(err_d)
  );

  typedef struct {
    logic [4:0]  i;
    logic [4:0]  j;
    logic [31:0] val;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one result until its ack is seen; returns with the ack cycle current.
  task automatic hs(input logic [4:0] i, input logic [4:0] j, input logic [31:0] v,
                    output int lat);
    z_i = i; z_j = j; z_out = v; z_stb = 1'b1; lat = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      lat++;
      if (z_ack) break;
    end
    chk("ack_seen", {31'd0, z_ack}, 32'd1);
    z_stb = 1'b0;
    if (i < 5'd4 && j < 5'd4) exp_mem[i * 4 + j] = v;
    $display("hs (%0d,%0d) <= %h ack latency %0d", i, j, v, lat);
  endtask

  task automatic hs_finish();
    tick();
    tick();
  endtask

  task automatic write_cell(input int i, input int j, input logic [31:0] v);
    int lat;
    hs(5'(i), 5'(j), v, lat);
    hs_finish();
  endtask

  // Runs a drain after mult_done was raised. abort_at >= 0 asserts clear at that element.
  task automatic drain(input bit bp, input int abort_at);
    int n = 0;
    int first = -1;
    bit seen_done = 1'b0;
    bit aborted = 1'b0;
    out_ack = bp ? 1'b0 : 1'b1;
    for (int c = 0; c < 200 && !seen_done && !aborted; c++) begin
      tick();
      if (drain_done) begin
        seen_done = 1'b1;
      end else if (out_stb) begin
        if (first < 0) first = c;
        chk("drain_i", {27'd0, out_i}, 32'(n / 4));
        chk("drain_j", {27'd0, out_j}, 32'(n % 4));
        chk("drain_data", out_data, exp_mem[n]);
        if (!bp) chk("drain_consec", 32'(c - first), 32'(n));
        $display("drain (%0d,%0d) = %h ack %0d", out_i, out_j, out_data, bp ? (c % 2) : 1);
        if (n == abort_at) begin
          clear = 1'b1;
          tick();
          clear = 1'b0;
          chk("abort_stb", {31'd0, out_stb}, 32'd0);
          chk("abort_err", {31'd0, err}, 32'd0);
          chk("abort_state", 32'(dut.r_state), 32'd0);
          aborted = 1'b1;
        end else begin
          out_ack = bp ? 1'(c % 2) : 1'b1;
          if (out_ack) n++;
        end
      end
    end
    if (!aborted) begin
      chk("drain_count", 32'(n), 32'd16);
      chk("drain_done_seen", {31'd0, seen_done}, 32'd1);
      tick();
      chk("drain_done_pulse", {31'd0, drain_done}, 32'd0);
      chk("drain_stb_off", {31'd0, out_stb}, 32'd0);
    end
    out_ack = 1'b0;
  endtask

  initial begin
    int lat;
    int acks;
    logic [31:0] old_v;

    vecs[0] = '{5'd1, 5'd2, 32'h3F80_0000, 32'h3F80_0000, 1};
    vecs[1] = '{5'd0, 5'd0, 32'h3F80_0000, 32'h3F80_0000, 1};
    vecs[2] = '{5'd0, 5'd0, 32'h4000_0000, 32'h4000_0000, 1};
    vecs[3] = '{5'd0, 5'd0, 32'h4040_0000, 32'h4040_0000, 1};
    vecs[4] = '{5'd3, 5'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};

    rst = 1'b1; clear = 1'b0; z_out = '0; z_i = '0; z_j = '0; z_stb = 1'b0;
    mult_done = 1'b0; rd_i = '0; rd_j = '0; out_ack = 1'b0;
    z_out_d = '0; zi_d = '0; zj_d = '0; zs_d = 1'b0; rdi_d = '0; rdj_d = '0;
    clear_d = 1'b0; mdone_d = 1'b0; oack_d = 1'b0;
    for (int k = 0; k < 16; k++) exp_mem[k] = '0;

    #1;
    chk("rst_z_ack", {31'd0, z_ack}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_ij", {22'd0, out_i, out_j}, 32'd0);
    chk("rst_out_stb", {31'd0, out_stb}, 32'd0);
    chk("rst_drain_done", {31'd0, drain_done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      hs(vecs[v].i, vecs[v].j, vecs[v].val, lat);
      chk("vec_latency", 32'(lat), 32'(vecs[v].exp_lat));
      hs_finish();
      rd_i = vecs[v].i; rd_j = vecs[v].j;
      tick();
      chk("vec_read", rd_data, vecs[v].exp_rd);
      chk("vec_err", {31'd0, err}, 32'd0);
    end
    rd_i = 5'd1; rd_j = 5'd2; tick();
    chk("read_keep_12", rd_data, 32'h3F80_0000);
    rd_i = 5'd5; rd_j = 5'd0; tick();
    chk("read_oor", rd_data, 32'd0);

    // Write and read of the same cell in one cycle returns the old value.
    rd_i = 5'd0; rd_j = 5'd0; tick();
    old_v = exp_mem[0];
    hs(5'd0, 5'd0, 32'h4080_0000, lat);
    tick();
    chk("raw_old", rd_data, old_v);
    tick();
    chk("raw_new", rd_data, 32'h4080_0000);
    chk("wr_cnt_6", 32'(dut.r_wr_cnt), 32'd6);

    // ACK_DELAY=3 instance: latency and abort from DELAY.
    z_out_d = 32'h1111_1111; zi_d = 5'd2; zj_d = 5'd1; zs_d = 1'b1; lat = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      lat++;
      if (za_d) break;
    end
    chk("delay_latency", 32'(lat), 32'd4);
    zs_d = 1'b0;
    tick(); tick();
    rdi_d = 5'd2; rdj_d = 5'd1; tick();
    chk("delay_read", rdd_d, 32'h1111_1111);
    $display("delay hs (2,1) <= 11111111 ack latency %0d", lat);
    z_out_d = 32'h2222_2222; zs_d = 1'b1; acks = 0;
    tick(); tick();
    zs_d = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (za_d) acks++;
    end
    chk("delay_abort_ack", 32'(acks), 32'd0);
    chk("delay_abort_read", rdd_d, 32'h1111_1111);
    chk("delay_wr_cnt", 32'(dut_d.r_wr_cnt), 32'd1);

    // Full run: 64 partial-sum writes, then drain with out_ack held high.
    clear = 1'b1; tick(); clear = 1'b0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          write_cell(i, j, {8'(k), 8'(i), 8'(j), 8'hA5});
    chk("full_wr_cnt", 32'(dut.r_wr_cnt), 32'd64);
    mult_done = 1'b1;
    drain(1'b0, -1);
    chk("full_err", {31'd0, err}, 32'd0);

    // Backpressure drain of the same matrix.
    mult_done = 1'b0; tick();
    mult_done = 1'b1;
    drain(1'b1, -1);
    chk("bp_err", {31'd0, err}, 32'd0);

    // Done after only 63 writes flags an error but still drains.
    mult_done = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    for (int n = 0; n < 63; n++)
      write_cell((n % 16) / 4, n % 4, 32'h5000_0000 + 32'(n));
    chk("short_wr_cnt", 32'(dut.r_wr_cnt), 32'd63);
    mult_done = 1'b1;
    drain(1'b0, -1);
    chk("short_err", {31'd0, err}, 32'd1);

    // Clear during the drain at element 7.
    mult_done = 1'b0; tick();
    mult_done = 1'b1;
    drain(1'b0, 7);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_idle_stb", {31'd0, out_stb}, 32'd0);
    end
    chk("abort_wr_cnt", 32'(dut.r_wr_cnt), 32'd0);
    mult_done = 1'b0; tick();

    // Out-of-range result index: acked, no write, error set.
    hs(5'd5, 5'd0, 32'hBAD0_BAD0, lat);
    chk("oor_latency", 32'(lat), 32'd1);
    hs_finish();
    chk("oor_err", {31'd0, err}, 32'd1);
    chk("oor_wr_cnt", 32'(dut.r_wr_cnt), 32'd0);
    rd_i = 5'd1; rd_j = 5'd0; tick();
    chk("oor_no_alias", rd_data, exp_mem[4]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
